// File: rtl/controle_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier controller.
// This package holds the 3-bit state codes, the default operand width and the strobe decoder.
package controle_mult_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef struct packed {
        logic load;
        logic sh;
        logic ad;
        logic done;
    } strobes_t;

    // The counter never holds a value wider than N-1, so it needs at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Each state drives at most one strobe, so the strobes can never overlap.
    function automatic strobes_t decode_state(input logic [2:0] state);
        strobes_t s;
        s = '0;
        case (state)
            S_LOAD:  s.load = 1'b1;
            S_ADD:   s.ad   = 1'b1;
            S_SHIFT: s.sh   = 1'b1;
            S_DONE:  s.done = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controle_mult_contador_bits.sv
// Counter of the multiplier bits processed so far, with a synchronous clear and an enable.
// tc flags the last bit; the count saturates there instead of wrapping.
module contador_bits
    import controle_mult_pkg::*;
#(
    parameter int N = N_DEFAULT
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int           W    = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/controle_mult.sv
// Moore FSM that sequences a shift-and-add multiplier accumulator (Load/Ad/Sh strobes, Done flag).
// Optional macro CONTROLE_DONE_HOLD_EN keeps DONE asserted while St stays high.
module controle_mult
    import controle_mult_pkg::*;
#(
    parameter int N = N_DEFAULT
)
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic St,
    input  logic M,
    output logic Load,
    output logic Sh,
    output logic Ad,
    output logic Done
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;
    strobes_t   strb;

    contador_bits #(.N(N)) u_contador (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = St ? S_LOAD : S_IDLE;
            S_LOAD:  state_next = S_TEST;
            S_TEST:  state_next = M ? S_ADD : S_SHIFT;
            S_ADD:   state_next = S_SHIFT;
            S_SHIFT: state_next = cnt_tc ? S_DONE : S_TEST;
`ifdef CONTROLE_DONE_HOLD_EN
            S_DONE:  state_next = St ? S_DONE : S_IDLE;
`else
            S_DONE:  state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // The counter advances on every shift except the last, so it still reads N-1 when DONE is entered.
    assign cnt_clr = (state == S_LOAD);
    assign cnt_en  = (state == S_SHIFT) && !cnt_tc;

    assign strb = decode_state(state);
    assign Load = strb.load;
    assign Sh   = strb.sh;
    assign Ad   = strb.ad;
    assign Done = strb.done;

endmodule

// File: tb/tb_controle_mult.sv
// Scoreboard bench for controle_mult with a behavioural 9-bit shift-and-add accumulator driving M.
// Stimulus pushes expected latency/add count/product/Done length; a negedge monitor pops and checks.
module tb_controle_mult;

    localparam int N = 4;
`ifdef CONTROLE_DONE_HOLD_EN
    localparam int HOLD_LEN = 2;
`else
    localparam int HOLD_LEN = 1;
`endif

    typedef struct {
        int lat;
        int k;
        int prod;
        int dlen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st = 1'b0;
    logic       m;
    logic       load, sh, ad, done;
    logic [8:0] acc = '0;
    logic [3:0] mplier = '0;
    logic [3:0] mcand = '0;

    logic chk_zero = 1'b0;
    logic tmo = 1'b0;
    logic end_req = 1'b0;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Multiplier a, multiplicand b, ones in a, cycles from St sample to Done, product.
    localparam int NV = 4;
    int v_a  [NV] = '{0, 15, 13, 10};
    int v_b  [NV] = '{5, 15, 11, 7};
    int v_k  [NV] = '{0, 4, 3, 2};
    int v_lat[NV] = '{10, 14, 13, 12};
    int v_p  [NV] = '{0, 225, 143, 70};

    always #5 clk = ~clk;

    controle_mult #(.N(N)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .St    (st),
        .M     (m),
        .Load  (load),
        .Sh    (sh),
        .Ad    (ad),
        .Done  (done)
    );

    assign m = acc[0];

    always @(posedge clk) begin
        if (load)
            acc <= {5'b0, mplier};
        else if (ad)
            acc[8:4] <= {1'b0, acc[7:4]} + {1'b0, mcand};
        else if (sh)
            acc <= acc >> 1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        bit   active = 0;
        bit   in_done = 0;
        int   cyc = 0;
        int   shc = 0;
        int   adc = 0;
        int   dlen = 0;
        exp_t cur;
        cur = '{0, 0, 0, 0};
        forever begin
            @(negedge clk);
            tests++;
            if ($countones({load, sh, ad, done}) > 1) begin
                fails++;
                $display("FAIL onehot: strobes L/S/A/D=%b, required at most one high", {load, sh, ad, done});
            end
            if (chk_zero) begin
                tests++;
                if ({load, sh, ad, done} != 4'b0) begin
                    fails++;
                    $display("FAIL idle_outputs: L/S/A/D=%b, required 0000", {load, sh, ad, done});
                end
                active  = 0;
                in_done = 0;
            end else begin
                if (load) begin
                    if (active) begin
                        tests++;
                        fails++;
                        $display("FAIL restart: Load at cycle %0d of running operation, required none", cyc);
                    end
                    active = 1;
                    cyc = 1;
                    shc = 0;
                    adc = 0;
                end else if (active) begin
                    cyc++;
                    if (sh) shc++;
                    if (ad) adc++;
                end
                if (done && !in_done) begin
                    in_done = 1;
                    dlen = 1;
                    tests++;
                    if (!active || exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: Done=1 with no operation pending, required 0");
                    end else begin
                        cur = exp_q.pop_front();
                        tests += 3;
                        if (cyc != cur.lat) begin
                            fails++;
                            $display("FAIL latency: got %0d cycles, required %0d", cyc, cur.lat);
                        end
                        if (shc != N || adc != cur.k) begin
                            fails++;
                            $display("FAIL pulse_count: Sh=%0d Ad=%0d, required Sh=%0d Ad=%0d", shc, adc, N, cur.k);
                        end
                        if (int'(acc) != cur.prod) begin
                            fails++;
                            $display("FAIL product: got %0d, required %0d", acc, cur.prod);
                        end
                    end
                    active = 0;
                end else if (done && in_done) begin
                    dlen++;
                end else if (!done && in_done) begin
                    in_done = 0;
                    tests++;
                    if (dlen != cur.dlen) begin
                        fails++;
                        $display("FAIL done_length: got %0d cycles, required %0d", dlen, cur.dlen);
                    end
                end
            end
            if (tmo) begin
                tests++;
                fails++;
                $display("FAIL timeout: expected DUT event did not occur, required within bound");
            end
            if (end_req) begin
                tests++;
                if (exp_q.size() != 0 || active) begin
                    fails++;
                    $display("FAIL leftover: %0d expected results pending, active=%0d, required 0/0", exp_q.size(), active);
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    task automatic pulse_tmo();
        @(posedge clk); #1 tmo = 1'b1;
        @(posedge clk); #1 tmo = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        if (!found) pulse_tmo();
    endtask

    task automatic check_zero_cycle();
        @(posedge clk); #1 chk_zero = 1'b1;
        @(posedge clk); #1 chk_zero = 1'b0;
    endtask

    task automatic run_op(input int a, input int b, input int k, input int lat, input int p, input bit hold_st);
        exp_q.push_back('{lat, k, p, hold_st ? HOLD_LEN : 1});
        mplier = 4'(a);
        mcand  = 4'(b);
        st = 1'b1;
        @(posedge clk); #1;
        if (!hold_st) st = 1'b0;
        wait_done();
        @(posedge clk); #1 st = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin : stimulus
        rst_n = 1'b0;
        st = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_zero = 1'b1;
        @(posedge clk); #1 chk_zero = 1'b0;
        rst_n = 1'b1;
        check_zero_cycle();

        for (int i = 0; i < NV; i++)
            run_op(v_a[i], v_b[i], v_k[i], v_lat[i], v_p[i], 1'b0);

        // Abort during the add of the second bit, then a clean operation.
        begin
            int  adn = 0;
            bit  hit = 0;
            mplier = 4'd15;
            mcand  = 4'd15;
            st = 1'b1;
            @(posedge clk); #1 st = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (ad) adn++;
                if (adn == 2) begin
                    hit = 1;
                    break;
                end
            end
            if (!hit) pulse_tmo();
            rst_n = 1'b0;
            @(posedge clk); #1 chk_zero = 1'b1;
            @(posedge clk); #1 chk_zero = 1'b0;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        run_op(15, 15, 4, 14, 225, 1'b0);

        // St held high for the whole operation and one cycle into DONE.
        run_op(3, 9, 2, 12, 27, 1'b1);
        check_zero_cycle();

        @(posedge clk); #1 end_req = 1'b1;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
